// File: rtl/cache_line_valid_ctrl_pkg.sv
// Shared constants and flush FSM encoding for the instruction-cache valid-flag controller.
package cache_line_valid_ctrl_pkg;

  localparam int FLUSH_SINGLE = 0;
  localparam int FLUSH_SWEEP  = 1;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_SWEEP = 2'd1,
    FS_DONE  = 2'd2
  } flush_state_e;

endpackage

// File: rtl/cache_line_valid_ctrl_onehot_decoder.sv
// Combinational IN_W -> 2**IN_W one-hot decoder; every index value maps to exactly one line.
module onehot_decoder
  import cache_line_valid_ctrl_pkg::*;
#(
  parameter int IN_W = 5
) (
  input  logic [IN_W-1:0]      idx,
  output logic [2**IN_W-1:0]   onehot
);

  always_comb begin
    onehot      = '0;
    onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/cache_line_valid_ctrl.sv
// Per-line valid flags with set / invalidate / flush, registered lookup and incremental valid count.
//   state    | meaning
//   FS_IDLE  | no flush in progress, set/inv accepted
//   FS_SWEEP | clearing line[ptr] each cycle, flush_busy=1, user updates dropped
//   FS_DONE  | flush_done pulse cycle, a new flush_req may restart the sweep
module cache_line_valid_ctrl
  import cache_line_valid_ctrl_pkg::*;
#(
  parameter int INDEX_W    = 5,
  parameter int FLUSH_MODE = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [INDEX_W-1:0]    lookup_index,
  output logic                  lookup_hit,
  input  logic                  set_valid,
  input  logic [INDEX_W-1:0]    set_index,
  input  logic                  inv_one,
  input  logic [INDEX_W-1:0]    inv_index,
  input  logic                  flush_req,
  output logic                  flush_busy,
  output logic                  flush_done,
  output logic [2**INDEX_W-1:0] valid_vec,
  output logic [INDEX_W:0]      valid_count
);

  localparam int LINES = 2**INDEX_W;
  localparam int CNT_W = INDEX_W + 1;

  logic [LINES-1:0]   set_oh, inv_oh, set_stb, inv_stb;
  logic [LINES-1:0]   valid_d, valid_q;
  logic [CNT_W-1:0]   count_d, count_q;
  logic [INDEX_W-1:0] ptr_d, ptr_q;
  flush_state_e       state_d, state_q;
  logic               pend_d, pend_q, done_d, done_q, busy_d, busy_q, hit_d, hit_q;
  logic               user_upd, inc, dec;

  onehot_decoder #(.IN_W(INDEX_W)) u_set_dec (.idx(set_index), .onehot(set_oh));
  onehot_decoder #(.IN_W(INDEX_W)) u_inv_dec (.idx(inv_index), .onehot(inv_oh));

  always_comb begin
    set_stb  = set_valid ? set_oh : '0;
    inv_stb  = inv_one ? inv_oh : '0;
    // invalidate beats set when both target the same line
    inc      = |(set_stb & ~valid_q & ~inv_stb);
    dec      = |(inv_stb & valid_q);
    valid_d  = valid_q;
    count_d  = count_q;
    state_d  = state_q;
    ptr_d    = ptr_q;
    pend_d   = 1'b0;
    done_d   = 1'b0;
    user_upd = 1'b1;
    if (FLUSH_MODE == FLUSH_SINGLE) begin
      pend_d = flush_req;
      done_d = pend_q;
      if (flush_req) begin
        valid_d  = '0;
        count_d  = '0;
        user_upd = 1'b0;
      end
    end else begin
      case (state_q)
        FS_IDLE, FS_DONE: begin
          state_d = FS_IDLE;
          if (flush_req) begin
            state_d  = FS_SWEEP;
            ptr_d    = '0;
            user_upd = 1'b0;
          end
        end
        FS_SWEEP: begin
          user_upd       = 1'b0;
          valid_d[ptr_q] = 1'b0;
          count_d        = count_q - CNT_W'(valid_q[ptr_q]);
          ptr_d          = ptr_q + 1'b1;
          if (ptr_q == '1) begin
            state_d = FS_DONE;
            done_d  = 1'b1;
          end
        end
        default: state_d = FS_IDLE;
      endcase
    end
    if (user_upd) begin
      valid_d = (valid_q | set_stb) & ~inv_stb;
      count_d = count_q + CNT_W'(inc) - CNT_W'(dec);
    end
    busy_d = (state_d == FS_SWEEP);
    hit_d  = valid_q[lookup_index] & ~busy_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      count_q <= '0;
      ptr_q   <= '0;
      state_q <= FS_IDLE;
      pend_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
      ptr_q   <= ptr_d;
      state_q <= state_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      hit_q   <= hit_d;
    end
  end

  assign valid_vec   = valid_q;
  assign valid_count = count_q;
  assign flush_busy  = busy_q;
  assign flush_done  = done_q;
  assign lookup_hit  = hit_q;

endmodule

// File: tb/tb_cache_line_valid_ctrl.sv
// Scoreboard bench: three builds (32-line single flush, 32-line sweep, 8-line sweep) share one stimulus stream.
module tb_cache_line_valid_ctrl;

  typedef struct {
    logic [31:0] vec;
    int          cnt;
    bit          hit;
    bit          busy;
    bit          done;
  } exp_t;

  logic       clk;
  logic       reset, set_valid, inv_one, flush_req;
  logic [4:0] set_index, inv_index, lookup_index;

  logic [31:0] vv0, vv1;
  logic [7:0]  vv2;
  logic [5:0]  vc0, vc1;
  logic [3:0]  vc2;
  logic        h0, h1, h2, b0, b1, b2, d0, d1, d2;

  int total = 0;
  int bad   = 0;

  exp_t q0[$], q1[$], q2[$];

  // reference model state: one entry per build
  bit mv[3][32];
  int mlines[3] = '{32, 32, 8};
  int mmode[3]  = '{0, 1, 1};
  bit msweep[3];
  int mpos[3];
  bit mpend[3];

  cache_line_valid_ctrl #(.INDEX_W(5), .FLUSH_MODE(0)) dut0 (
    .clk(clk), .reset(reset), .lookup_index(lookup_index), .lookup_hit(h0),
    .set_valid(set_valid), .set_index(set_index), .inv_one(inv_one), .inv_index(inv_index),
    .flush_req(flush_req), .flush_busy(b0), .flush_done(d0), .valid_vec(vv0), .valid_count(vc0));

  cache_line_valid_ctrl #(.INDEX_W(5), .FLUSH_MODE(1)) dut1 (
    .clk(clk), .reset(reset), .lookup_index(lookup_index), .lookup_hit(h1),
    .set_valid(set_valid), .set_index(set_index), .inv_one(inv_one), .inv_index(inv_index),
    .flush_req(flush_req), .flush_busy(b1), .flush_done(d1), .valid_vec(vv1), .valid_count(vc1));

  cache_line_valid_ctrl #(.INDEX_W(3), .FLUSH_MODE(1)) dut2 (
    .clk(clk), .reset(reset), .lookup_index(lookup_index[2:0]), .lookup_hit(h2),
    .set_valid(set_valid), .set_index(set_index[2:0]), .inv_one(inv_one), .inv_index(inv_index[2:0]),
    .flush_req(flush_req), .flush_busy(b2), .flush_done(d2), .valid_vec(vv2), .valid_count(vc2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void chk(string name, int k, longint act, longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL d%0d.%s at %0t: got 0x%0h want 0x%0h", k, name, $time, act, req);
    end
  endfunction

  function automatic exp_t model_step(int k, bit rst, bit sv, int si, bit io, int ii, bit fr, int li);
    exp_t e;
    bit   old[32];
    int   L = mlines[k];
    int   s = si % L, i = ii % L, l = li % L;
    bit   done = 1'b0;
    old = mv[k];
    if (rst) begin
      for (int n = 0; n < 32; n++) mv[k][n] = 1'b0;
      msweep[k] = 1'b0; mpos[k] = 0; mpend[k] = 1'b0;
    end else if (mmode[k] == 0) begin
      done = mpend[k];
      mpend[k] = fr;
      if (fr) for (int n = 0; n < 32; n++) mv[k][n] = 1'b0;
      else begin
        if (sv) mv[k][s] = 1'b1;
        if (io) mv[k][i] = 1'b0;
      end
    end else if (msweep[k]) begin
      mv[k][mpos[k]] = 1'b0;
      mpos[k]++;
      if (mpos[k] == L) begin msweep[k] = 1'b0; done = 1'b1; end
    end else if (fr) begin
      msweep[k] = 1'b1; mpos[k] = 0;
    end else begin
      if (sv) mv[k][s] = 1'b1;
      if (io) mv[k][i] = 1'b0;
    end
    e.hit  = (!rst && !msweep[k]) ? old[l] : 1'b0;
    e.busy = msweep[k];
    e.done = done;
    e.cnt  = 0;
    e.vec  = '0;
    for (int n = 0; n < 32; n++) begin
      e.vec[n] = mv[k][n];
      e.cnt += int'(mv[k][n]);
    end
    return e;
  endfunction

  task automatic step(bit rst, bit sv, int si, bit io, int ii, bit fr, int li);
    @(negedge clk);
    reset = rst; set_valid = sv; set_index = 5'(si); inv_one = io;
    inv_index = 5'(ii); flush_req = fr; lookup_index = 5'(li);
    q0.push_back(model_step(0, rst, sv, si, io, ii, fr, li));
    q1.push_back(model_step(1, rst, sv, si, io, ii, fr, li));
    q2.push_back(model_step(2, rst, sv, si, io, ii, fr, li));
  endtask

  task automatic idle(int li);
    step(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, li);
  endtask

  task automatic fill_all();
    for (int n = 0; n < 32; n++) step(1'b0, 1'b1, n, 1'b0, 0, 1'b0, n);
  endtask

  task automatic rnd_step(bit allow_rst);
    step(allow_rst && ($urandom_range(59) == 0), $urandom_range(1) == 1, int'($urandom_range(31)),
         $urandom_range(2) == 0, int'($urandom_range(31)), $urandom_range(24) == 0,
         int'($urandom_range(31)));
  endtask

  function automatic void cmp(int k, longint vec, longint cnt, bit hit, bit busy, bit done, exp_t e);
    chk("valid_vec", k, vec, longint'(e.vec));
    chk("valid_count", k, cnt, longint'(e.cnt));
    chk("lookup_hit", k, longint'(hit), longint'(e.hit));
    chk("flush_busy", k, longint'(busy), longint'(e.busy));
    chk("flush_done", k, longint'(done), longint'(e.done));
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin e = q0.pop_front(); cmp(0, longint'(vv0), longint'(vc0), h0, b0, d0, e); end
      if (q1.size() > 0) begin e = q1.pop_front(); cmp(1, longint'(vv1), longint'(vc1), h1, b1, d1, e); end
      if (q2.size() > 0) begin e = q2.pop_front(); cmp(2, longint'(vv2), longint'(vc2), h2, b2, d2, e); end
    end
  end

  initial begin : driver
    reset = 1'b1; set_valid = 1'b0; inv_one = 1'b0; flush_req = 1'b0;
    set_index = '0; inv_index = '0; lookup_index = '0;
    step(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 0);
    step(1'b1, 1'b1, 3, 1'b0, 0, 1'b1, 0);
    // lines 0, 7, 31 then registered lookups of 7 and 8
    step(1'b0, 1'b1, 0, 1'b0, 0, 1'b0, 0);
    step(1'b0, 1'b1, 7, 1'b0, 0, 1'b0, 0);
    step(1'b0, 1'b1, 31, 1'b0, 0, 1'b0, 0);
    idle(7);
    idle(8);
    idle(31);
    // same-index set+inv, then different indices
    step(1'b0, 1'b1, 4, 1'b0, 0, 1'b0, 4);
    step(1'b0, 1'b1, 4, 1'b1, 4, 1'b0, 4);
    step(1'b0, 1'b1, 4, 1'b0, 0, 1'b0, 4);
    step(1'b0, 1'b1, 5, 1'b1, 4, 1'b0, 5);
    step(1'b0, 1'b1, 5, 1'b0, 0, 1'b0, 5);
    step(1'b0, 1'b0, 0, 1'b1, 9, 1'b0, 9);
    // full cache then flush with a competing set
    fill_all();
    step(1'b0, 1'b1, 3, 1'b1, 6, 1'b1, 3);
    for (int n = 0; n < 40; n++) begin
      if (n % 5 == 2) step(1'b0, 1'b1, n, 1'b1, n + 1, 1'b1, n);
      else idle(31 - n % 32);
    end
    // reset part-way through a sweep, then a fresh sweep from line 0
    fill_all();
    step(1'b0, 1'b0, 0, 1'b0, 0, 1'b1, 0);
    for (int n = 0; n < 10; n++) idle(n);
    step(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 0);
    idle(0);
    fill_all();
    step(1'b0, 1'b0, 0, 1'b0, 0, 1'b1, 0);
    for (int n = 0; n < 36; n++) idle(n % 32);
    // flush issued in the done cycle of the 8-line build restarts it
    step(1'b0, 1'b0, 0, 1'b0, 0, 1'b1, 0);
    for (int n = 0; n < 8; n++) idle(n);
    step(1'b0, 1'b0, 0, 1'b0, 0, 1'b1, 0);
    for (int n = 0; n < 40; n++) idle(n % 32);
    for (int n = 0; n < 800; n++) rnd_step(1'b1);
    repeat (3) @(posedge clk);
    #2;
    chk("queues_drained", 0, longint'(q0.size() + q1.size() + q2.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
